// File: rtl/interrupt_controller.sv
// Interrupt controller with edge-triggered pending latches, a per-line enable
// mask, fixed priority (line 0 highest) and a single non-nesting service slot.
//
// Ports:
//   clk           - clock, all registers update on the rising edge
//   reset         - asynchronous active-high reset
//   interruptions - raw interrupt lines, synchronous to clk
//   enable_we     - write strobe for the enable register
//   enable_in     - new enable value (1 = line enabled)
//   enable_out    - current enable register
//   int_req       - interrupt request to the cpu
//   int_vector    - index of the requested line, valid while int_req = 1
//   int_ack       - cpu pulse: vector taken
//   int_eoi       - cpu pulse: end of service
//   pending       - latched edges not yet acknowledged
//   in_service    - one-hot line being serviced, 0 when none
module interrupt_controller #(
   parameter int N_IRQ = 8,
   localparam int VW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] interruptions,
   input  logic             enable_we,
   input  logic [N_IRQ-1:0] enable_in,
   output logic [N_IRQ-1:0] enable_out,
   output logic             int_req,
   output logic [VW-1:0]    int_vector,
   input  logic             int_ack,
   input  logic             int_eoi,
   output logic [N_IRQ-1:0] pending,
   output logic [N_IRQ-1:0] in_service
);

   typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

   state_t           state, state_next;
   logic [N_IRQ-1:0] prev;
   logic [N_IRQ-1:0] edges;
   logic [N_IRQ-1:0] eligible;
   logic [N_IRQ-1:0] clr;
   logic [N_IRQ-1:0] pending_next;
   logic [N_IRQ-1:0] in_service_next;
   logic             int_req_next;
   logic [VW-1:0]    int_vector_next;

   // Lowest set index wins: scan from the top so the last hit is the lowest.
   function automatic logic [VW-1:0] highest_priority(input logic [N_IRQ-1:0] v);
      logic [VW-1:0] idx;
      idx = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (v[i]) idx = VW'(i);
      end
      return idx;
   endfunction

   function automatic logic [N_IRQ-1:0] one_hot(input logic [VW-1:0] idx);
      logic [N_IRQ-1:0] r;
      r = '0;
      r[idx] = 1'b1;
      return r;
   endfunction

   assign edges    = interruptions & ~prev;
   // Uses the registered enable, so a same-cycle enable write cannot affect
   // the IDLE decision.
   assign eligible = pending & enable_out;

   always_comb begin
      state_next      = state;
      int_req_next    = int_req;
      int_vector_next = int_vector;
      in_service_next = in_service;
      clr             = '0;
      unique case (state)
         IDLE: begin
            if (|eligible) begin
               state_next      = REQUEST;
               int_req_next    = 1'b1;
               int_vector_next = highest_priority(eligible);
            end
         end
         REQUEST: begin
            if (int_ack) begin
               clr             = one_hot(int_vector);
               in_service_next = one_hot(int_vector);
               int_req_next    = 1'b0;
               state_next      = SERVICE;
            end
         end
         SERVICE: begin
            if (int_eoi) begin
               in_service_next = '0;
               state_next      = IDLE;
            end
         end
         default: begin
            state_next   = IDLE;
            int_req_next = 1'b0;
         end
      endcase
      // Clear before set: a new edge on the acknowledged line keeps it pending.
      pending_next = (pending & ~clr) | edges;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         int_req    <= 1'b0;
         int_vector <= '0;
         pending    <= '0;
         in_service <= '0;
         enable_out <= '1;
         // All ones so lines already high at release do not look like edges.
         prev       <= '1;
      end else begin
         state      <= state_next;
         int_req    <= int_req_next;
         int_vector <= int_vector_next;
         pending    <= pending_next;
         in_service <= in_service_next;
         prev       <= interruptions;
         if (enable_we) enable_out <= enable_in;
      end
   end

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] interruptions = 8'h00;
   logic       enable_we = 1'b0;
   logic [7:0] enable_in = 8'h00;
   logic [7:0] enable_out;
   logic       int_req;
   logic [2:0] int_vector;
   logic       int_ack = 1'b0;
   logic       int_eoi = 1'b0;
   logic [7:0] pending;
   logic [7:0] in_service;

   int n_cmp = 0;
   int n_bad = 0;

   interrupt_controller #(.N_IRQ(8)) dut (
      .clk(clk), .reset(reset), .interruptions(interruptions),
      .enable_we(enable_we), .enable_in(enable_in), .enable_out(enable_out),
      .int_req(int_req), .int_vector(int_vector), .int_ack(int_ack),
      .int_eoi(int_eoi), .pending(pending), .in_service(in_service)
   );

   always #5 clk = ~clk;

   // Reference model: the controller is "waiting for ack" (m_req), "busy
   // servicing" (m_svc != 0) or otherwise free to raise a request.
   logic [7:0] m_pend = 8'h00;
   logic [7:0] m_en   = 8'hFF;
   logic [7:0] m_last = 8'hFF;
   logic [7:0] m_svc  = 8'h00;
   logic       m_req  = 1'b0;
   int         m_vec  = 0;

   task automatic model_step();
      logic [7:0] rising, elig, np;
      if (reset) begin
         m_pend = 8'h00; m_en = 8'hFF; m_last = 8'hFF;
         m_svc = 8'h00; m_req = 1'b0; m_vec = 0;
         return;
      end
      rising = interruptions & ~m_last;
      elig   = m_pend & m_en;
      np     = m_pend | rising;
      if (m_req) begin
         if (int_ack) begin
            np    = (m_pend & ~(8'd1 << m_vec)) | rising;
            m_svc = 8'd1 << m_vec;
            m_req = 1'b0;
         end
      end else if (m_svc != 8'h00) begin
         if (int_eoi) m_svc = 8'h00;
      end else if (elig != 8'h00) begin
         m_req = 1'b1;
         m_vec = -1;
         for (int i = 0; i < 8; i++)
            if (elig[i] && m_vec < 0) m_vec = i;
      end
      if (enable_we) m_en = enable_in;
      m_last = interruptions;
      m_pend = np;
   endtask

   task automatic cmp(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, #1 after the rising edge.
   always begin
      @(posedge clk);
      model_step();
      #1;
      cmp("model.int_req", int_req, m_req);
      if (m_req) cmp("model.int_vector", int_vector, m_vec);
      cmp("model.pending", pending, m_pend);
      cmp("model.in_service", in_service, m_svc);
      cmp("model.enable_out", enable_out, m_en);
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic ack_then_eoi();
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      int_eoi = 1'b1; tick(); int_eoi = 1'b0;
   endtask

   initial begin
      tick(2);
      // Reset state
      cmp("rst.enable_out", enable_out, 8'hFF);
      cmp("rst.pending", pending, 8'h00);
      cmp("rst.in_service", in_service, 8'h00);
      cmp("rst.int_req", int_req, 0);
      cmp("rst.int_vector", int_vector, 0);
      reset = 1'b0;
      tick();

      // Single line
      interruptions = 8'h04; tick();
      cmp("single.pending", pending, 8'h04);
      cmp("single.req_early", int_req, 0);
      interruptions = 8'h00; tick();
      cmp("single.int_req", int_req, 1);
      cmp("single.vector", int_vector, 2);
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      cmp("single.pend_after_ack", pending, 8'h00);
      cmp("single.insvc", in_service, 8'h04);
      cmp("single.req_after_ack", int_req, 0);
      int_eoi = 1'b1; tick(); int_eoi = 1'b0;
      cmp("single.insvc_eoi", in_service, 8'h00);

      // Priority
      interruptions = 8'hA0; tick();
      interruptions = 8'h00; tick();
      cmp("prio.vector5", int_vector, 5);
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      int_eoi = 1'b1; tick(); int_eoi = 1'b0;
      cmp("prio.gap", int_req, 0);
      tick();
      cmp("prio.req7", int_req, 1);
      cmp("prio.vector7", int_vector, 7);
      ack_then_eoi();

      // Masking
      enable_we = 1'b1; enable_in = 8'hFE; tick(); enable_we = 1'b0;
      interruptions = 8'h01; tick();
      interruptions = 8'h00; tick(2);
      cmp("mask.pending", pending, 8'h01);
      cmp("mask.no_req", int_req, 0);
      enable_we = 1'b1; enable_in = 8'hFF; tick(); enable_we = 1'b0;
      cmp("mask.old_enable", int_req, 0);
      tick();
      cmp("mask.req", int_req, 1);
      cmp("mask.vector0", int_vector, 0);
      ack_then_eoi();

      // Hold and no nesting
      interruptions = 8'h08; tick();
      interruptions = 8'h00; tick();
      cmp("hold.vector3", int_vector, 3);
      interruptions = 8'h01; tick();
      interruptions = 8'h00; tick();
      cmp("hold.still3", int_vector, 3);
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      cmp("hold.insvc", in_service, 8'h08);
      cmp("hold.pend0", pending, 8'h01);
      tick(2);
      cmp("hold.no_nest", int_req, 0);
      int_eoi = 1'b1; tick(); int_eoi = 1'b0;
      tick();
      cmp("hold.req0", int_req, 1);
      cmp("hold.vector0", int_vector, 0);
      ack_then_eoi();

      // Collision of ack with a new edge on the same line
      interruptions = 8'h02; tick();
      interruptions = 8'h00; tick();
      cmp("coll.vector1", int_vector, 1);
      interruptions = 8'h02; int_ack = 1'b1; tick();
      interruptions = 8'h00; int_ack = 1'b0;
      cmp("coll.insvc", in_service, 8'h02);
      cmp("coll.pend1", pending, 8'h02);
      int_eoi = 1'b1; tick(); int_eoi = 1'b0;
      tick();
      cmp("coll.rereq", int_req, 1);
      ack_then_eoi();

      // Reset mid-service with a line held high
      interruptions = 8'h10; tick(2);
      cmp("rstsvc.vector4", int_vector, 4);
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      cmp("rstsvc.insvc", in_service, 8'h10);
      reset = 1'b1; #1;
      cmp("rstsvc.async_insvc", in_service, 8'h00);
      cmp("rstsvc.async_enable", enable_out, 8'hFF);
      cmp("rstsvc.async_req", int_req, 0);
      tick(2);
      reset = 1'b0; tick(3);
      cmp("rstsvc.no_req", int_req, 0);
      cmp("rstsvc.no_pend", pending, 8'h00);
      interruptions = 8'h00; tick();
      interruptions = 8'h10; tick(2);
      cmp("rstsvc.req4", int_req, 1);
      cmp("rstsvc.vec4b", int_vector, 4);
      interruptions = 8'h00;
      ack_then_eoi();

      // Randomized traffic, checked only by the model process
      for (int c = 0; c < 3000; c++) begin
         interruptions = 8'($urandom);
         enable_we     = ($urandom_range(0, 9) == 0);
         enable_in     = 8'($urandom);
         int_ack       = ($urandom_range(0, 2) == 0);
         int_eoi       = ($urandom_range(0, 3) == 0);
         reset         = ($urandom_range(0, 199) == 0);
         tick();
      end
      reset = 1'b0; int_ack = 1'b0; int_eoi = 1'b0; enable_we = 1'b0;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 The block SHALL have the parameter N_IRQ, default 8, giving the number of interrupt lines; the block is verified only at 8.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all registers update on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port interruptions, input, 8 bits: raw interrupt lines, already synchronous to clk (timer, i_o_manager).
REQ-005 The block SHALL have the port enable_we, input, 1 bit: write strobe for the enable register.
REQ-006 The block SHALL have the port enable_in, input, 8 bits: new enable value; 1 = line enabled.
REQ-007 The block SHALL have the port enable_out, output, 8 bits: current enable register.
REQ-008 The block SHALL have the port int_req, output, 1 bit: interrupt request to the cpu.
REQ-009 The block SHALL have the port int_vector, output, 3 bits: index of the requested line; valid while int_req=1.
REQ-010 The block SHALL have the port int_ack, input, 1 bit: one-cycle pulse from the cpu, meaning the vector is taken.
REQ-011 The block SHALL have the port int_eoi, input, 1 bit: one-cycle pulse from the cpu, meaning end of service.
REQ-012 The block SHALL have the port pending, output, 8 bits: latched, not-yet-acknowledged edges.
REQ-013 The block SHALL have the port in_service, output, 8 bits: one-hot line being serviced, or 0 when none.

Function
REQ-014 Edge detect: the block SHALL keep a register prev holding interruptions from the previous cycle; edge[i] = interruptions[i] & ~prev[i].
REQ-015 On every cycle with edge[i]=1, pending[i] SHALL be set at the next rising edge, regardless of the enable value.
REQ-016 A level held high SHALL produce exactly one pending set; the line must go low and high again to pend again.
REQ-017 Eligible = pending & enable_out; priority SHALL be fixed, with bit 0 highest and bit 7 lowest.
REQ-018 The FSM SHALL have three states: IDLE, REQUEST, SERVICE; outputs are registered.
REQ-019 IDLE: if eligible != 0, the FSM SHALL go to REQUEST, and int_vector SHALL latch the index of the highest-priority eligible bit in the same edge.
REQ-020 REQUEST: int_req=1, and int_vector SHALL be held stable until int_ack, even if pending, enable or interruptions change.
REQ-021 REQUEST with int_ack=1: the block SHALL clear pending[int_vector], set in_service[int_vector] and go to SERVICE; int_req=0 from the next cycle.
REQ-022 SERVICE: no nesting; new edges SHALL still set pending, but no request is raised; int_eoi=1 SHALL clear in_service and return the FSM to IDLE.
REQ-023 Latency: an edge sampled at edge n SHALL set pending after edge n, and give int_req=1 after edge n+1 if the FSM was in IDLE and the line is enabled.
REQ-024 Back-to-back: after int_eoi, the FSM is in IDLE for one cycle; with a remaining eligible bit, int_req=1 SHALL return after 2 edges.
REQ-025 int_ack in IDLE or SERVICE SHALL be ignored.
REQ-026 int_eoi in IDLE or REQUEST SHALL be ignored.
REQ-027 When int_ack and a new edge hit the same line in the same cycle, the set SHALL win: pending stays 1, and in_service is still set.
REQ-028 enable_we SHALL update enable_out at the next edge; a disabled line keeps its pending bit, and is requested once re-enabled.
REQ-029 When enable_we and the IDLE-to-REQUEST decision fall in the same cycle, the decision SHALL use the old enable value.

Reset
REQ-030 While reset=1, the block SHALL asynchronously force state=IDLE, int_req=0, int_vector=0, pending=0, in_service=0, enable_out=8'hFF, and prev=8'hFF.
REQ-031 With prev reset to all ones, lines already high at reset release SHALL NOT pend until they toggle.
REQ-032 Reset asserted in REQUEST or SERVICE SHALL abandon the transaction; after release, no request is raised until a new edge arrives.

Verification
REQ-033 Single line: pulse interruptions=8'h04 for 1 cycle -> pending=8'h04 after 1 edge; int_req=1, int_vector=2 after 2 edges; int_ack -> pending=0, in_service=8'h04; int_eoi -> in_service=0, IDLE.
REQ-034 Priority: interruptions 8'h00 -> 8'hA0 in the same cycle -> int_vector=5; after ack and eoi -> int_req=1, int_vector=7 two edges later.
REQ-035 Masking: enable_in=8'hFE written, then edge on line 0 -> pending=8'h01, int_req stays 0; write 8'hFF -> int_req=1, int_vector=0.
REQ-036 Hold and no-nesting: in REQUEST with vector 3, an edge on line 0 -> int_vector stays 3; after ack, line 0 pends, and int_req=0 until eoi; then vector 0.
REQ-037 Collision: int_ack on vector 1 in the same cycle as a new edge on line 1 -> in_service=8'h02, and pending[1]=1.
REQ-038 Reset mid-service: assert reset in SERVICE with interruptions=8'h10 held high -> all outputs at reset values, enable_out=8'hFF; no int_req after release until line 4 toggles.
